deser_demux16: RTL

Serial-to-parallel deserializer: the receive-side counterpart of the 16:1 bit-select serializer path. It takes a framed serial bit stream, demultiplexes each accepted bit into position `sel` of a 16-bit capture word (LSB first, so that bit `k` lands in `word[k]`), and hands complete words downstream through a valid/ready register stage. It sits between a serial link receiver and any 16-bit word consumer. It also provides frame-error and idle-timeout recovery.

---
 rtl/deser_pkg.sv | 21 ++
 rtl/deser_idle_timer.sv | 38 +++
 rtl/deser_demux16.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// ---------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the 16-bit serial-to-parallel deserializer.
//   WORD_W        : width of the parallel capture/output word
//   IDX_W         : width of the bit-select index (log2 of WORD_W)
//   TIMER_W       : width of the idle-timeout counter
//   deser_state_t : frame FSM states
// ---------------------------------------------------------------------------
package deser_pkg;

    localparam int WORD_W  = 16;
    localparam int IDX_W   = 4;
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } deser_state_t;

endpackage

// File: rtl/deser_idle_timer.sv
// ---------------------------------------------------------------------------
// idle_timer
// Saturating idle counter with a programmable limit.
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   clear  : zero the counter (wins over enable)
//   enable : count one idle cycle
//   limit  : number of idle cycles that constitutes a timeout
//   hit    : this idle cycle is the limit-th one in a row
// ---------------------------------------------------------------------------
module idle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   count_plus_one;

    // hit looks one step ahead, so the abort lands on the same edge
    // that would have recorded the limit-th idle cycle
    assign count_plus_one = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign hit            = enable && !clear && (count_plus_one == {1'b0, limit});

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/deser_demux16.sv
// ---------------------------------------------------------------------------
// deser_demux16
// Serial-to-parallel deserializer: accepted bits are demultiplexed into
// position sel of a 16-bit capture word (LSB first), and completed words
// are handed downstream through a valid/ready output register.
//   TIMEOUT   : idle cycles tolerated inside a frame (1..255)
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_bit    : serial data bit
//   in_valid  : in_bit is valid this cycle
//   in_start  : with in_valid, marks bit 0 of a new frame
//   in_ready  : an input beat is accepted this cycle
//   out_word  : completed word
//   out_valid : out_word holds an unconsumed word
//   out_ready : downstream consumes out_word
//   sel       : index the next accepted bit is written to
//   busy      : a frame is in progress
//   frame_err : one-cycle pulse on misplaced start or timeout abort
// ---------------------------------------------------------------------------
module deser_demux16
    import deser_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
    input  logic              in_start,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  sel,
    output logic              busy,
    output logic              frame_err
);

    deser_state_t      state;
    logic [WORD_W-1:0] cap;
    logic [WORD_W-1:0] cap_next;
    logic [WORD_W-1:0] write_mask;
    logic [IDX_W-1:0]  write_idx;
    logic              accept;
    logic              stage_free;
    logic              timeout_hit;
    logic              timer_clear;
    logic              timer_enable;

    assign in_ready   = !rst && (state != HOLD);
    assign busy       = (state != IDLE);
    assign accept     = in_valid && in_ready;
    assign stage_free = !out_valid || out_ready;

    // A start beat always lands in bit 0, even when it interrupts a frame
    assign write_idx = in_start ? '0 : sel;

    // 1:16 demux: only the addressed capture bit takes in_bit
    always_comb begin
        write_mask            = '0;
        write_mask[write_idx] = 1'b1;
        cap_next              = (cap & ~write_mask) | ({WORD_W{in_bit}} & write_mask);
    end

    assign timer_enable = (state == SHIFT) && !accept;
    assign timer_clear  = !timer_enable;

    idle_timer #(
        .WIDTH (TIMER_W)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .limit  (TIMER_W'(TIMEOUT)),
        .hit    (timeout_hit)
    );

    // Frame FSM with capture and output registers. The output-stage
    // consume clear is written first so a same-edge load overrides it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            cap       <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept && in_start) begin
                        cap   <= cap_next;
                        sel   <= IDX_W'(1);
                        state <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (accept) begin
                        cap <= cap_next;
                        if (in_start && (sel != '0)) begin
                            frame_err <= 1'b1;
                            sel       <= IDX_W'(1);
                        end else if (sel == '1) begin
                            sel <= '0;
                            if (stage_free) begin
                                out_word  <= cap_next;
                                out_valid <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            sel <= sel + IDX_W'(1);
                        end
                    end else if (timeout_hit) begin
                        frame_err <= 1'b1;
                        sel       <= '0;
                        state     <= IDLE;
                    end
                end

                HOLD: begin
                    // The finished word waits in cap until the old one is taken
                    if (out_valid && out_ready) begin
                        out_word  <= cap;
                        out_valid <= 1'b1;
                        sel       <= '0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    sel   <= '0;
                end
            endcase
        end
    end

endmodule
